// File: rtl/alu_seq.sv
// Multi-cycle ALU. Arithmetic and logic ops finish in one cycle. Shifts, rotates and shift-add multiply
// run one bit per cycle. Zero/carry live in an internal flag register that also feeds ADC/SBC.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             update_z_c,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] r_hi,
  output logic             zero,
  output logic             carry,
  output logic             dbg_state
);
  localparam int SW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_ADC  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_SBC  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_NAND = 4'h7;
  localparam logic [3:0] OP_SHL  = 4'h8;
  localparam logic [3:0] OP_SAR  = 4'h9;
  localparam logic [3:0] OP_ROL  = 4'hA;
  localparam logic [3:0] OP_ROR  = 4'hB;
  localparam logic [3:0] OP_MUL  = 4'hC;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t           r_state, w_next;
  logic [3:0]       r_op;
  logic             r_uzc;
  logic [WIDTH-1:0] r_work;   // shift/rotate value, or multiplier / product low half
  logic [WIDTH-1:0] r_acc;    // product high half
  logic [WIDTH-1:0] r_mcand;
  logic [SW:0]      r_cnt;

  logic [SW-1:0]    w_s;
  logic             w_launch, w_iter, w_last;

  // Handshake: start is sampled only while busy=0. An accepted immediate op raises done for exactly
  // the next cycle; an iterative op holds busy for n cycles, then raises done for one cycle.
  // done and busy are never high together, and start during the done cycle is accepted.
  assign w_s       = b[SW-1:0];
  assign w_launch  = start && (r_state == S_IDLE);
  assign w_iter    = ((op inside {OP_SHL, OP_SAR, OP_ROL, OP_ROR}) && (w_s != '0)) || (op == OP_MUL);
  assign w_last    = (r_state == S_RUN) && (r_cnt == (SW+1)'(1));
  assign busy      = (r_state == S_RUN);
  assign dbg_state = (r_state == S_RUN);

  logic [WIDTH:0]   w_sum, w_diff;
  logic [WIDTH-1:0] w_imm_r;
  logic             w_imm_c, w_imm_cwr, w_imm_fwr;

  always_comb begin
    w_sum     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, (op == OP_ADC) & carry};
    w_diff    = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, (op == OP_SBC) & carry};
    w_imm_r   = a;
    w_imm_c   = carry;
    w_imm_cwr = 1'b0;
    w_imm_fwr = 1'b1;
    case (op)
      OP_ADD, OP_ADC: begin
        w_imm_r   = w_sum[WIDTH-1:0];
        w_imm_c   = w_sum[WIDTH];
        w_imm_cwr = 1'b1;
      end
      // Bit WIDTH of the (WIDTH+1)-bit difference is the unsigned borrow.
      OP_SUB, OP_SBC: begin
        w_imm_r   = w_diff[WIDTH-1:0];
        w_imm_c   = w_diff[WIDTH];
        w_imm_cwr = 1'b1;
      end
      OP_AND:  w_imm_r = a & b;
      OP_OR:   w_imm_r = a | b;
      OP_XOR:  w_imm_r = a ^ b;
      OP_NAND: w_imm_r = ~(a & b);
      OP_SHL, OP_SAR, OP_ROL, OP_ROR, OP_MUL: w_imm_r = a;
      default: begin
        w_imm_r   = '0;
        w_imm_fwr = 1'b0;
      end
    endcase
  end

  logic [WIDTH:0]   w_madd;
  logic [WIDTH-1:0] w_step_work, w_step_acc;
  logic             w_step_c;

  always_comb begin
    w_madd      = {1'b0, r_acc} + (r_work[0] ? {1'b0, r_mcand} : '0);
    w_step_work = r_work;
    w_step_acc  = r_acc;
    w_step_c    = 1'b0;
    case (r_op)
      OP_SHL: begin w_step_work = {r_work[WIDTH-2:0], 1'b0};         w_step_c = r_work[WIDTH-1]; end
      OP_SAR: begin w_step_work = {r_work[WIDTH-1], r_work[WIDTH-1:1]}; w_step_c = r_work[0];    end
      OP_ROL: begin w_step_work = {r_work[WIDTH-2:0], r_work[WIDTH-1]}; w_step_c = r_work[WIDTH-1]; end
      OP_ROR: begin w_step_work = {r_work[0], r_work[WIDTH-1:1]};       w_step_c = r_work[0];    end
      OP_MUL: begin
        w_step_work = {w_madd[0], r_work[WIDTH-1:1]};
        w_step_acc  = w_madd[WIDTH:1];
        w_step_c    = (w_madd[WIDTH:1] != '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_launch && w_iter) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op    <= '0;
      r_uzc   <= 1'b0;
      r_work  <= '0;
      r_acc   <= '0;
      r_mcand <= '0;
      r_cnt   <= '0;
      done    <= 1'b0;
      r       <= '0;
      r_hi    <= '0;
      zero    <= 1'b0;
      carry   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (w_launch) begin
        r_op    <= op;
        r_uzc   <= update_z_c;
        r_mcand <= a;
        r_acc   <= '0;
        r_work  <= (op == OP_MUL) ? b : a;
        r_cnt   <= (op == OP_MUL) ? (SW+1)'(WIDTH) : {1'b0, w_s};
        if (!w_iter) begin
          done <= 1'b1;
          r    <= w_imm_r;
          r_hi <= '0;
          if (update_z_c && w_imm_fwr) zero  <= (w_imm_r == '0);
          if (update_z_c && w_imm_cwr) carry <= w_imm_c;
        end
      end else if (r_state == S_RUN) begin
        r_work <= w_step_work;
        r_acc  <= w_step_acc;
        r_cnt  <= r_cnt - (SW+1)'(1);
        if (w_last) begin
          done <= 1'b1;
          r    <= w_step_work;
          r_hi <= (r_op == OP_MUL) ? w_step_acc : '0;
          if (r_uzc) begin
            zero  <= (w_step_work == '0);
            carry <= w_step_c;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: scenario tasks push expected results into a queue as each op
// is launched and pop/compare them once done is seen.
module tb_alu_seq;
  localparam int W  = 8;
  localparam int EW = 1 + 8 + 2*W + 2;   // {overlap, n, r_hi, r, zero, carry}

  localparam logic [3:0] OP_ADD = 4'h0, OP_ADC = 4'h1, OP_SUB = 4'h2, OP_SBC = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4, OP_OR = 4'h5, OP_XOR = 4'h6, OP_NAND = 4'h7;
  localparam logic [3:0] OP_SHL = 4'h8, OP_SAR = 4'h9, OP_ROL = 4'hA, OP_ROR = 4'hB;
  localparam logic [3:0] OP_MUL = 4'hC, OP_RSV = 4'hD;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   op = '0;
  logic [W-1:0] a = '0, b = '0;
  logic         uzc = 1'b0;
  logic         busy, done, zero, carry, dbg_state;
  logic [W-1:0] r, r_hi;

  int n_cmp = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q[$];
  logic m_z = 1'b0, m_c = 1'b0;

  typedef struct packed {
    logic [3:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          uzc;
    logic [EW-1:0] exp;
  } step_t;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .update_z_c(uzc),
    .busy(busy), .done(done), .r(r), .r_hi(r_hi), .zero(zero), .carry(carry), .dbg_state(dbg_state)
  );

  function automatic logic [EW-1:0] pack(input int n, input logic [W-1:0] rr, hi, input logic z, c);
    return {1'b0, 8'(n), hi, rr, z, c};
  endfunction

  function automatic step_t mk(input logic [3:0] o, input logic [W-1:0] x, y, input logic u,
                               input logic [EW-1:0] e);
    step_t s;
    s.op = o; s.a = x; s.b = y; s.uzc = u; s.exp = e;
    return s;
  endfunction

  function automatic string fmt(input logic [EW-1:0] v);
    return $sformatf("ovl=%b n=%0d r_hi=%h r=%h z=%b c=%b",
                     v[EW-1], v[EW-2 -: 8], v[2*W+1 -: W], v[W+1 -: W], v[1], v[0]);
  endfunction

  // Behavioural reference written from the arithmetic definitions, not the bit-serial datapath.
  function automatic logic [EW-1:0] model(input logic [3:0] o, input logic [W-1:0] x, y, input logic u,
                                          input logic zi, ci, output logic zo, co);
    int unsigned ux = x;
    int unsigned uy = y;
    int unsigned s  = y % W;
    logic [W-1:0]   rr = '0;
    logic [W-1:0]   hi = '0;
    logic [2*W-1:0] p;
    logic           c  = ci;
    logic           wr = 1'b1;
    int             n  = 0;
    case (o)
      OP_ADD:  begin rr = W'(ux + uy);      c = ((ux + uy) >= (1 << W)); end
      OP_ADC:  begin rr = W'(ux + uy + ci); c = ((ux + uy + ci) >= (1 << W)); end
      OP_SUB:  begin rr = W'(ux - uy);      c = (ux < uy); end
      OP_SBC:  begin rr = W'(ux - uy - ci); c = (ux < uy + ci); end
      OP_AND:  rr = x & y;
      OP_OR:   rr = x | y;
      OP_XOR:  rr = x ^ y;
      OP_NAND: rr = ~(x & y);
      OP_SHL:  if (s != 0) begin rr = x << s; c = x[W-s]; n = s; end else rr = x;
      OP_SAR:  if (s != 0) begin rr = W'($signed(x) >>> s); c = x[s-1]; n = s; end else rr = x;
      OP_ROL:  if (s != 0) begin rr = (x << s) | (x >> (W - s)); c = rr[0]; n = s; end else rr = x;
      OP_ROR:  if (s != 0) begin rr = (x >> s) | (x << (W - s)); c = rr[W-1]; n = s; end else rr = x;
      OP_MUL:  begin
        p  = (2*W)'(x) * (2*W)'(y);
        rr = p[W-1:0]; hi = p[2*W-1:W]; c = (hi != '0); n = W;
      end
      default: begin rr = '0; wr = 1'b0; end
    endcase
    zo = (u && wr) ? (rr == '0) : zi;
    co = u ? c : ci;
    return pack(n, rr, hi, zo, co);
  endfunction

  // Launch one op at the current negedge and wait (bounded) for done. Returns all-X on timeout.
  task automatic drive_op(input logic [3:0] o, input logic [W-1:0] x, y, input logic u,
                          output logic [EW-1:0] got);
    int busy_n = 0;
    int guard  = 0;
    op = o; a = x; b = y; uzc = u; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op = 4'($urandom_range(0, 15)); a = W'($urandom); b = W'($urandom); uzc = 1'($urandom_range(0, 1));
    while (!done && guard < 64) begin
      if (busy) busy_n++;
      guard++;
      @(negedge clk);
    end
    if (!done) got = 'x;
    else       got = {busy, 8'(busy_n), r_hi, r, zero, carry};
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, done, r, r_hi, zero, carry} !== '0) begin
      n_err++;
      $display("FAIL reset_hold: got busy=%b done=%b r=%h r_hi=%h z=%b c=%b, expected all 0",
               busy, done, r, r_hi, zero, carry);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({busy, done, r, r_hi, zero, carry} !== '0) begin
      n_err++;
      $display("FAIL reset_release: got busy=%b done=%b r=%h r_hi=%h z=%b c=%b, expected all 0",
               busy, done, r, r_hi, zero, carry);
    end
  endtask

  task automatic test_add_carry();
    step_t st[$];
    logic [EW-1:0] got, exp;
    st.push_back(mk(OP_ADD, 8'hF0, 8'h20, 1'b1, pack(0, 8'h10, 8'h00, 1'b0, 1'b1)));
    st.push_back(mk(OP_ADC, 8'h01, 8'h01, 1'b1, pack(0, 8'h03, 8'h00, 1'b0, 1'b0)));
    foreach (st[i]) begin
      exp_q.push_back(st[i].exp);
      drive_op(st[i].op, st[i].a, st[i].b, st[i].uzc, got);
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin n_err++; $display("FAIL add_carry[%0d]: got %s, expected %s", i, fmt(got), fmt(exp)); end
    end
  endtask

  task automatic test_subtract();
    step_t st[$];
    logic [EW-1:0] got, exp;
    st.push_back(mk(OP_SUB, 8'h05, 8'h05, 1'b1, pack(0, 8'h00, 8'h00, 1'b1, 1'b0)));
    st.push_back(mk(OP_SUB, 8'h03, 8'h05, 1'b1, pack(0, 8'hFE, 8'h00, 1'b0, 1'b1)));
    st.push_back(mk(OP_SBC, 8'h10, 8'h01, 1'b1, pack(0, 8'h0E, 8'h00, 1'b0, 1'b0)));
    foreach (st[i]) begin
      exp_q.push_back(st[i].exp);
      drive_op(st[i].op, st[i].a, st[i].b, st[i].uzc, got);
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin n_err++; $display("FAIL subtract[%0d]: got %s, expected %s", i, fmt(got), fmt(exp)); end
    end
  endtask

  task automatic test_shift();
    step_t st[$];
    logic [EW-1:0] got, exp;
    st.push_back(mk(OP_SAR, 8'h81, 8'h03, 1'b1, pack(3, 8'hF0, 8'h00, 1'b0, 1'b0)));
    st.push_back(mk(OP_SHL, 8'h81, 8'h01, 1'b1, pack(1, 8'h02, 8'h00, 1'b0, 1'b1)));
    st.push_back(mk(OP_SAR, 8'h81, 8'h08, 1'b1, pack(0, 8'h81, 8'h00, 1'b0, 1'b1)));
    st.push_back(mk(OP_SHL, 8'h03, 8'h07, 1'b1, pack(7, 8'h80, 8'h00, 1'b0, 1'b1)));
    foreach (st[i]) begin
      exp_q.push_back(st[i].exp);
      drive_op(st[i].op, st[i].a, st[i].b, st[i].uzc, got);
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin n_err++; $display("FAIL shift[%0d]: got %s, expected %s", i, fmt(got), fmt(exp)); end
    end
  endtask

  task automatic test_rotate();
    step_t st[$];
    logic [EW-1:0] got, exp;
    st.push_back(mk(OP_ROL, 8'h81, 8'h01, 1'b1, pack(1, 8'h03, 8'h00, 1'b0, 1'b1)));
    st.push_back(mk(OP_ROR, 8'h01, 8'h04, 1'b1, pack(4, 8'h10, 8'h00, 1'b0, 1'b0)));
    st.push_back(mk(OP_ROR, 8'h01, 8'h01, 1'b0, pack(1, 8'h80, 8'h00, 1'b0, 1'b0)));
    st.push_back(mk(OP_ROL, 8'h00, 8'hF7, 1'b0, pack(7, 8'h00, 8'h00, 1'b0, 1'b0)));
    foreach (st[i]) begin
      exp_q.push_back(st[i].exp);
      drive_op(st[i].op, st[i].a, st[i].b, st[i].uzc, got);
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin n_err++; $display("FAIL rotate[%0d]: got %s, expected %s", i, fmt(got), fmt(exp)); end
    end
  endtask

  task automatic test_multiply();
    step_t st[$];
    logic [EW-1:0] got, exp;
    st.push_back(mk(OP_MUL, 8'hFF, 8'hFF, 1'b1, pack(8, 8'h01, 8'hFE, 1'b0, 1'b1)));
    st.push_back(mk(OP_AND, 8'h0F, 8'hF0, 1'b1, pack(0, 8'h00, 8'h00, 1'b1, 1'b1)));
    st.push_back(mk(OP_MUL, 8'h0D, 8'h0B, 1'b1, pack(8, 8'h8F, 8'h00, 1'b0, 1'b0)));
    st.push_back(mk(OP_RSV, 8'h55, 8'hAA, 1'b1, pack(0, 8'h00, 8'h00, 1'b0, 1'b0)));
    foreach (st[i]) begin
      exp_q.push_back(st[i].exp);
      drive_op(st[i].op, st[i].a, st[i].b, st[i].uzc, got);
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin n_err++; $display("FAIL multiply[%0d]: got %s, expected %s", i, fmt(got), fmt(exp)); end
    end
  endtask

  task automatic test_abort();
    logic [EW-1:0] got, exp;
    // Leave non-zero flags behind so the reset clear is visible.
    exp_q.push_back(pack(0, 8'h00, 8'h00, 1'b1, 1'b1));
    drive_op(OP_SUB, 8'h00, 8'h01, 1'b1, got);
    drive_op(OP_ADD, 8'hFF, 8'h01, 1'b1, got);
    exp = exp_q.pop_front();
    n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL abort_setup: got %s, expected %s", fmt(got), fmt(exp)); end
    op = OP_MUL; a = 8'hFF; b = 8'hFF; uzc = 1'b1; start = 1'b1;
    @(negedge clk);
    op = OP_ADD; a = 8'h01; b = 8'h01;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_err++; $display("FAIL abort_ignore_start: got busy=%b done=%b, expected busy=1 done=0", busy, done);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, r, r_hi, zero, carry} !== '0) begin
      n_err++;
      $display("FAIL abort_reset: got busy=%b done=%b r=%h r_hi=%h z=%b c=%b, expected all 0",
               busy, done, r, r_hi, zero, carry);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_err++; $display("FAIL abort_no_done[%0d]: got busy=%b done=%b, expected 0/0", i, busy, done);
      end
    end
    exp_q.push_back(pack(0, 8'h02, 8'h00, 1'b0, 1'b0));
    drive_op(OP_ADD, 8'h01, 8'h01, 1'b1, got);
    exp = exp_q.pop_front();
    n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL abort_recover: got %s, expected %s", fmt(got), fmt(exp)); end
  endtask

  task automatic test_back_to_back();
    step_t st[$];
    logic [EW-1:0] got, exp;
    st.push_back(mk(OP_XOR,  8'hFF, 8'h0F, 1'b1, pack(0, 8'hF0, 8'h00, 1'b0, 1'b0)));
    st.push_back(mk(OP_OR,   8'h00, 8'h00, 1'b1, pack(0, 8'h00, 8'h00, 1'b1, 1'b0)));
    st.push_back(mk(OP_NAND, 8'h0F, 8'hF0, 1'b1, pack(0, 8'hFF, 8'h00, 1'b0, 1'b0)));
    st.push_back(mk(OP_SUB,  8'h00, 8'h01, 1'b1, pack(0, 8'hFF, 8'h00, 1'b0, 1'b1)));
    st.push_back(mk(OP_ADC,  8'h00, 8'h00, 1'b1, pack(0, 8'h01, 8'h00, 1'b0, 1'b0)));
    st.push_back(mk(OP_NAND, 8'hFF, 8'hFF, 1'b1, pack(0, 8'h00, 8'h00, 1'b1, 1'b0)));
    foreach (st[i]) begin
      exp_q.push_back(st[i].exp);
      drive_op(st[i].op, st[i].a, st[i].b, st[i].uzc, got);
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin n_err++; $display("FAIL back_to_back[%0d]: got %s, expected %s", i, fmt(got), fmt(exp)); end
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0) begin n_err++; $display("FAIL done_single_pulse: got done=%b, expected 0", done); end
  endtask

  task automatic test_random();
    logic [EW-1:0] got, exp;
    logic [3:0]    o;
    logic [W-1:0]  x, y;
    logic          u, nz, nc;
    // ADD 0+0 with flag update puts the model and the DUT flags in a known state.
    exp_q.push_back(model(OP_ADD, '0, '0, 1'b1, m_z, m_c, nz, nc));
    m_z = nz; m_c = nc;
    drive_op(OP_ADD, '0, '0, 1'b1, got);
    exp = exp_q.pop_front();
    n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL random_init: got %s, expected %s", fmt(got), fmt(exp)); end
    for (int i = 0; i < 60; i++) begin
      o = 4'($urandom_range(0, 15));
      x = W'($urandom);
      y = W'($urandom);
      u = ($urandom_range(0, 3) != 0);
      exp_q.push_back(model(o, x, y, u, m_z, m_c, nz, nc));
      m_z = nz; m_c = nc;
      drive_op(o, x, y, u, got);
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL random[%0d] op=%h a=%h b=%h uzc=%b: got %s, expected %s", i, o, x, y, u, fmt(got), fmt(exp));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add_carry();
    test_subtract();
    test_shift();
    test_rotate();
    test_multiply();
    test_abort();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
